// File: rtl/snake_game_ctrl.sv
// Game-state controller for the snake: filters PS/2 bytes into commands, paces
// moves off VGA frame ticks and sequences IDLE/INIT/RUN/PAUSE/DEAD.
module snake_game_ctrl #(
  parameter int FRAMES_PER_MOVE = 4,
  parameter int DEAD_FRAMES     = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [7:0] key_code,
  input  logic       Vsync,
  input  logic       died,
  output logic [1:0] dir,
  output logic       move_tick,
  output logic       init_snake,
  output logic       screen_black,
  output logic       screen_pause,
  output logic [2:0] state
);

  localparam int FW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
  localparam int DW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MOVE - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      key_sync_q, vs_sync_q;
  logic            skip_q, skip_d;
  logic [1:0]      dir_q, dir_d, next_dir_q, next_dir_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
  logic            move_tick_q, move_tick_d;
  logic            init_snake_q, init_snake_d;
  logic            screen_black_q, screen_black_d;
  logic            screen_pause_q, screen_pause_d;

  logic            key_evt, frame_tick;
  logic            is_arrow, is_space, is_esc, arrow_ok;
  logic [1:0]      arrow_dir;

  // Two flops to synchronise, a third to detect the edge.
  assign key_evt    = key_sync_q[1] & ~key_sync_q[2];
  assign frame_tick = ~vs_sync_q[1] & vs_sync_q[2];

  always_comb begin
    skip_d    = skip_q;
    is_arrow  = 1'b0;
    is_space  = 1'b0;
    is_esc    = 1'b0;
    arrow_dir = 2'b00;
    if (key_evt && key_code != 8'hE0) begin
      if (key_code == 8'hF0) begin
        skip_d = 1'b1;
      end else if (skip_q) begin
        skip_d = 1'b0;
      end else begin
        case (key_code)
          8'h75:   begin is_arrow = 1'b1; arrow_dir = 2'b00; end
          8'h72:   begin is_arrow = 1'b1; arrow_dir = 2'b01; end
          8'h6B:   begin is_arrow = 1'b1; arrow_dir = 2'b10; end
          8'h74:   begin is_arrow = 1'b1; arrow_dir = 2'b11; end
          8'h29:   is_space = 1'b1;
          8'h76:   is_esc   = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Opposite headings share bit 1 and differ in bit 0.
  assign arrow_ok = is_arrow && !((arrow_dir[1] == dir_q[1]) && (arrow_dir[0] != dir_q[0]));

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    next_dir_d  = next_dir_q;
    frame_cnt_d = frame_cnt_q;
    dead_cnt_d  = dead_cnt_q;
    move_tick_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_space) state_d = S_INIT;
      end
      S_INIT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (died) begin
          state_d = S_DEAD;
        end else begin
          if (arrow_ok) next_dir_d = arrow_dir;
          if (frame_tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
              frame_cnt_d = '0;
              move_tick_d = 1'b1;
              dir_d       = next_dir_q;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
          if (is_space)    state_d = S_PAUSE;
          else if (is_esc) state_d = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (is_space)    state_d = S_RUN;
        else if (is_esc) state_d = S_IDLE;
      end
      S_DEAD: begin
        if (frame_tick) begin
          if (dead_cnt_q == DEAD_LAST) state_d = S_IDLE;
          else dead_cnt_d = dead_cnt_q + 1'b1;
        end
        if (is_space)    state_d = S_INIT;
        else if (is_esc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_INIT && state_q != S_INIT) begin
      dir_d       = 2'b11;
      next_dir_d  = 2'b11;
      frame_cnt_d = '0;
    end
    if (state_d == S_DEAD && state_q != S_DEAD) dead_cnt_d = '0;

    init_snake_d   = (state_d == S_INIT);
    screen_black_d = (state_d == S_IDLE);
    screen_pause_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      key_sync_q     <= 3'b000;
      vs_sync_q      <= 3'b111;
      skip_q         <= 1'b0;
      dir_q          <= 2'b11;
      next_dir_q     <= 2'b11;
      frame_cnt_q    <= '0;
      dead_cnt_q     <= '0;
      move_tick_q    <= 1'b0;
      init_snake_q   <= 1'b0;
      screen_black_q <= 1'b1;
      screen_pause_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      key_sync_q     <= {key_sync_q[1:0], key_pressed};
      vs_sync_q      <= {vs_sync_q[1:0], Vsync};
      skip_q         <= skip_d;
      dir_q          <= dir_d;
      next_dir_q     <= next_dir_d;
      frame_cnt_q    <= frame_cnt_d;
      dead_cnt_q     <= dead_cnt_d;
      move_tick_q    <= move_tick_d;
      init_snake_q   <= init_snake_d;
      screen_black_q <= screen_black_d;
      screen_pause_q <= screen_pause_d;
    end
  end

  assign dir          = dir_q;
  assign move_tick    = move_tick_q;
  assign init_snake   = init_snake_q;
  assign screen_black = screen_black_q;
  assign screen_pause = screen_pause_q;
  assign state        = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: table of key/frame actions with expected
// state, heading and tick counts, plus cycle-exact latency, death and reset sequences.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_pressed = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       Vsync = 1'b1;
  logic       died = 1'b0;
  logic [1:0] dir;
  logic       move_tick, init_snake, screen_black, screen_pause;
  logic [2:0] state;

  snake_game_ctrl #(.FRAMES_PER_MOVE(4), .DEAD_FRAMES(120)) dut (
    .clk(clk), .reset(reset), .key_pressed(key_pressed), .key_code(key_code),
    .Vsync(Vsync), .died(died), .dir(dir), .move_tick(move_tick),
    .init_snake(init_snake), .screen_black(screen_black),
    .screen_pause(screen_pause), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         op;        // 0 = key byte, 1 = frames
    logic [7:0] data;
    int         n;
    logic [2:0] exp_state;
    logic [1:0] exp_dir;
    int         exp_ticks;
  } vec_t;

  vec_t tbl[33];
  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int frame_idx = 0;
  int last_tick_frame = 0;
  int prev_tick_frame = 0;

  always @(negedge clk) begin
    if (move_tick) begin
      tick_cnt <= tick_cnt + 1;
      prev_tick_frame <= last_tick_frame;
      last_tick_frame <= frame_idx;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int op, input logic [7:0] d, input int n,
                         input logic [2:0] st, input logic [1:0] dr, input int tk);
    tbl[i].op = op; tbl[i].data = d; tbl[i].n = n;
    tbl[i].exp_state = st; tbl[i].exp_dir = dr; tbl[i].exp_ticks = tk;
  endtask

  task automatic send_key(input logic [7:0] b);
    @(negedge clk);
    key_code = b;
    key_pressed = 1'b1;
    repeat (4) @(negedge clk);
    key_pressed = 1'b0;
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic send_frame();
    @(negedge clk);
    frame_idx++;
    Vsync = 1'b0;
    repeat (4) @(negedge clk);
    Vsync = 1'b1;
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic apply_range(input int lo, input int hi);
    int t0;
    for (int i = lo; i <= hi; i++) begin
      t0 = tick_cnt;
      if (tbl[i].op == 0) send_key(tbl[i].data);
      else repeat (tbl[i].n) send_frame();
      chk($sformatf("v%0d_state", i), int'(state), int'(tbl[i].exp_state));
      chk($sformatf("v%0d_dir", i), int'(dir), int'(tbl[i].exp_dir));
      chk($sformatf("v%0d_ticks", i), tick_cnt - t0, tbl[i].exp_ticks);
      chk($sformatf("v%0d_black", i), int'(screen_black), (tbl[i].exp_state == 3'd0) ? 1 : 0);
      chk($sformatf("v%0d_pause", i), int'(screen_pause), (tbl[i].exp_state == 3'd2) ? 0 : 1);
      $display("vec %0d op=%0d data=%h n=%0d state=%0d dir=%0d ticks=%0d",
               i, tbl[i].op, tbl[i].data, tbl[i].n, state, dir, tick_cnt - t0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_dir"}, int'(dir), 3);
    chk({tag, "_move_tick"}, int'(move_tick), 0);
    chk({tag, "_init_snake"}, int'(init_snake), 0);
    chk({tag, "_black"}, int'(screen_black), 1);
    chk({tag, "_pause"}, int'(screen_pause), 1);
  endtask

  initial begin
    int t0;
    // Vectors start in RUN heading right with the frame counter at 0.
    set_vec(0,  0, 8'hF0, 0, 3'd2, 2'd3, 0);
    set_vec(1,  0, 8'h29, 0, 3'd2, 2'd3, 0);   // space release: no pause
    set_vec(2,  1, 8'h00, 8, 3'd2, 2'd3, 2);
    set_vec(3,  0, 8'h6B, 0, 3'd2, 2'd3, 0);   // left while right: rejected
    set_vec(4,  1, 8'h00, 4, 3'd2, 2'd3, 1);
    set_vec(5,  0, 8'hE0, 0, 3'd2, 2'd3, 0);
    set_vec(6,  0, 8'h75, 0, 3'd2, 2'd3, 0);
    set_vec(7,  1, 8'h00, 4, 3'd2, 2'd0, 1);   // turn up on the tick
    set_vec(8,  0, 8'hE0, 0, 3'd2, 2'd0, 0);
    set_vec(9,  0, 8'hF0, 0, 3'd2, 2'd0, 0);
    set_vec(10, 0, 8'h74, 0, 3'd2, 2'd0, 0);   // right release: discarded
    set_vec(11, 1, 8'h00, 4, 3'd2, 2'd0, 1);
    set_vec(12, 1, 8'h00, 2, 3'd2, 2'd0, 0);
    set_vec(13, 0, 8'h29, 0, 3'd3, 2'd0, 0);   // pause at frame phase 2
    set_vec(14, 0, 8'hF0, 0, 3'd3, 2'd0, 0);
    set_vec(15, 0, 8'h29, 0, 3'd3, 2'd0, 0);
    set_vec(16, 1, 8'h00, 10, 3'd3, 2'd0, 0);
    set_vec(17, 0, 8'h6B, 0, 3'd3, 2'd0, 0);   // arrow ignored in pause
    set_vec(18, 0, 8'hF0, 0, 3'd3, 2'd0, 0);
    set_vec(19, 0, 8'h6B, 0, 3'd3, 2'd0, 0);
    set_vec(20, 0, 8'h29, 0, 3'd2, 2'd0, 0);
    set_vec(21, 1, 8'h00, 1, 3'd2, 2'd0, 0);
    set_vec(22, 1, 8'h00, 1, 3'd2, 2'd0, 1);   // phase kept across pause
    set_vec(23, 0, 8'hF0, 0, 3'd2, 2'd0, 0);
    set_vec(24, 0, 8'h29, 0, 3'd2, 2'd0, 0);
    set_vec(25, 0, 8'h6B, 0, 3'd2, 2'd0, 0);
    set_vec(26, 1, 8'h00, 3, 3'd2, 2'd0, 0);
    set_vec(27, 1, 8'h00, 119, 3'd4, 2'd0, 0);
    set_vec(28, 1, 8'h00, 1, 3'd0, 2'd0, 0);
    set_vec(29, 0, 8'h29, 0, 3'd2, 2'd3, 0);
    set_vec(30, 0, 8'h75, 0, 3'd2, 2'd3, 0);
    set_vec(31, 1, 8'h00, 4, 3'd2, 2'd0, 1);
    set_vec(32, 0, 8'h29, 0, 3'd3, 2'd0, 0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("reset");

    // Space with cycle-exact latency: IDLE -> INIT on E2, RUN on E3.
    @(negedge clk);
    key_code = 8'h29;
    key_pressed = 1'b1;
    @(negedge clk); chk("lat_e0_state", int'(state), 0);
    @(negedge clk); chk("lat_e1_state", int'(state), 0);
    @(negedge clk);
    chk("lat_e2_state", int'(state), 1);
    chk("lat_e2_init", int'(init_snake), 1);
    chk("lat_e2_dir", int'(dir), 3);
    @(negedge clk);
    chk("lat_e3_state", int'(state), 2);
    chk("lat_e3_init", int'(init_snake), 0);
    chk("lat_e3_black", int'(screen_black), 0);
    chk("lat_e3_pause", int'(screen_pause), 0);
    key_pressed = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    $display("seq space_start state=%0d dir=%0d", state, dir);

    apply_range(0, 2);
    chk("tick_spacing", last_tick_frame - prev_tick_frame, 4);
    $display("seq tick_spacing frames=%0d", last_tick_frame - prev_tick_frame);
    apply_range(3, 26);

    // died on the same cycle as the 4th frame tick: no move, straight to DEAD.
    t0 = tick_cnt;
    @(negedge clk);
    frame_idx++;
    Vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    died = 1'b1;
    @(negedge clk);
    died = 1'b0;
    chk("died_state", int'(state), 4);
    chk("died_move_tick", int'(move_tick), 0);
    chk("died_pause", int'(screen_pause), 1);
    Vsync = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("died_no_tick", tick_cnt - t0, 0);
    $display("seq died state=%0d ticks=%0d", state, tick_cnt - t0);

    apply_range(27, 32);

    // Reset pulsed while paused.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("pause_reset");
    reset = 1'b0;
    $display("seq pause_reset state=%0d dir=%0d black=%0d", state, dir, screen_black);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-state controller and move scheduler for the snake display path. Consumes raw PS/2 scan-code strobes, the VGA vertical sync and a `died` flag from the snake datapath. Produces the committed heading, a one-cycle move strobe every N frames, an init pulse and the screen blank/freeze controls. It sits between the `ps2` receiver/`display` timing and the snake position/rendering logic, replacing ad-hoc movement on `negedge Vsync` with a single-clock sequenced design.

## Interface
- `FRAMES_PER_MOVE`, 4: frame ticks between move strobes (≥1).
- `DEAD_FRAMES`, 120: frame ticks spent in DEAD before auto-return to IDLE (≥1).
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `key_pressed` input 1: asynchronous strobe from `ps2`, high ≥1 PS/2 clock per received byte.
- `key_code` input 8: last received byte; stable while `key_pressed` is high.
- `Vsync` input 1: asynchronous VGA vertical sync, active-low pulse.
- `died` input 1: synchronous to `clk`; snake collided (level or pulse).
- `dir` output 2: committed heading; 00 up, 01 down, 10 left, 11 right.
- `move_tick` output 1: one-cycle pulse; datapath advances one step.
- `init_snake` output 1: one-cycle pulse; datapath reloads its start position.
- `screen_black` output 1: force display black.
- `screen_pause` output 1: datapath frozen.
- `state` output 3: debug; IDLE=0, INIT=1, RUN=2, PAUSE=3, DEAD=4.

## Operation
- `key_pressed` and `Vsync` each pass through a 2-flop synchronizer plus a third delay flop. `key_evt` = sync rise. `frame_tick` = `Vsync` sync fall.
- Byte filter on `key_evt`:
  - 0xE0 is ignored; it does not disturb the skip flag.
  - 0xF0 sets `skip`.
  - If `skip` is set, the next non-E0 byte is discarded and `skip` clears.
  - Otherwise the byte is a make code: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x29 space, 0x76 esc. All other codes are ignored.
- IDLE:
  - `screen_black`=1, `screen_pause`=1.
  - space → INIT. All else ignored.
- INIT (exactly 1 cycle):
  - `init_snake`=1.
  - `dir`, `next_dir` ← 11.
  - Frame counter ← 0.
  - → RUN.
- RUN:
  - `screen_black`=0, `screen_pause`=0.
  - Arrow make code: `next_dir` ← code unless it is the opposite of the committed `dir` (up/down, left/right). Rejected codes leave `next_dir` unchanged. Last accepted arrow before a tick wins.
  - On `frame_tick`:
    - If count = `FRAMES_PER_MOVE`-1: count ← 0, `move_tick` ← 1, `dir` ← `next_dir`.
    - Else count increments.
  - space → PAUSE. esc → IDLE.
  - `died`=1 → DEAD. `died` has priority over any key or frame event in the same cycle; in that case no `move_tick` is issued.
- PAUSE:
  - `screen_pause`=1, `screen_black`=0.
  - Frame counter holds, so the move phase is preserved across resume.
  - Arrows ignored. space → RUN. esc → IDLE.
- DEAD:
  - `screen_pause`=1, `screen_black`=0.
  - Dead counter cleared on entry; increments per `frame_tick`. At `DEAD_FRAMES`-1 with a tick → IDLE.
  - space → INIT. esc → IDLE. `died` ignored.
- Counters are sized `$clog2` of their parameter (minimum 1 bit) and never exceed parameter-1.

## Timing
- Reset values:
  - `state`=IDLE, `dir`=11, `next_dir`=11.
  - `move_tick`=0, `init_snake`=0.
  - `screen_black`=1, `screen_pause`=1.
  - Both counters 0, `skip`=0, all sync flops cleared (`Vsync` sync flops reset to 1).
- Reset mid-game is effective on the next edge; any pending pulse is dropped.
- All outputs are registered.
- Key latency: with E0 the first edge sampling `key_pressed`=1, state and outputs change on E2.
- Frame latency: with E0 the first edge sampling `Vsync`=0, `move_tick` is high for the cycle following E2.
- `move_tick` and the `dir` update occur on the same edge.
- `init_snake` is high for exactly the one INIT cycle; RUN starts the next cycle.
- Tick spacing in RUN is exactly `FRAMES_PER_MOVE` frames, unaffected by key events.

## Test plan
- Reset, then space (0x29): `init_snake` high 1 cycle, `state` 0→1→2, `screen_black` 1→0, `dir`=11.
- RUN with 8 Vsync falls, `FRAMES_PER_MOVE`=4: exactly 2 `move_tick` pulses, 4 frames apart.
- RUN heading right:
  - Send 0x6B (left): rejected; next tick `dir`=11.
  - Send E0 75: next tick `dir`=00.
  - Send E0 F0 75 (release): `dir` unchanged.
- RUN, frames 1 and 2 of 4, then space: PAUSE, no ticks over 10 frames. Space again: first tick after 2 more frames.
- `died`=1 in the same cycle as the 4th `frame_tick`: no `move_tick`, `state`=4, `screen_pause`=1. After 120 frames (`DEAD_FRAMES`=120): `state`=0, `screen_black`=1.
- Space press followed by release (29, F0 29): single PAUSE entry, no toggle back. `reset` pulsed in PAUSE: all outputs return to reset values next cycle.
